// File: rtl/simmem_linkedlist_bank_rr.sv
// Per-ID linked-list response buffer over a shared entry pool.
// Releases list heads through a registered output stage with round-robin arbitration.
module simmem_linkedlist_bank_rr #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 2,
  parameter int unsigned Capacity  = 16,
  localparam int unsigned NumIds   = 2**IdWidth,
  localparam int unsigned PtrW     = $clog2(Capacity),
  localparam int unsigned CntW     = $clog2(Capacity + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NumIds-1:0]      release_en_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NumIds*CntW-1:0] id_count_o,
  output logic [CntW-1:0]        free_count_o
);

  logic [DataWidth-1:0] mem_q  [Capacity];
  logic [PtrW-1:0]      next_q [Capacity];
  logic [Capacity-1:0]  free_q;
  logic [PtrW-1:0]      head_q [NumIds];
  logic [PtrW-1:0]      tail_q [NumIds];
  logic [CntW-1:0]      len_q  [NumIds];
  logic [CntW-1:0]      free_cnt_q;
  logic [IdWidth-1:0]   rr_q;
  logic                 out_valid_q;
  logic [DataWidth-1:0] out_data_q;

  logic                 enq;
  logic                 deq;
  logic [IdWidth-1:0]   enq_id;
  logic [PtrW-1:0]      alloc;
  logic [NumIds-1:0]    elig;
  logic                 any_elig;
  logic [IdWidth-1:0]   win;
  logic [IdWidth-1:0]   idx;
  logic [PtrW-1:0]      deq_ptr;
  logic [NumIds-1:0]    enq_hit;
  logic [NumIds-1:0]    deq_hit;

  // Handshakes, lowest-free allocation and round-robin winner selection.
  always_comb begin
    in_ready_o = (free_cnt_q != '0);
    enq        = in_valid_i && in_ready_o;
    enq_id     = data_i[IdWidth-1:0];
    alloc      = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (free_q[i]) alloc = PtrW'(i);
    end
    for (int i = 0; i < NumIds; i++) begin
      elig[i] = (len_q[i] != '0) && release_en_i[i];
    end
    any_elig = 1'b0;
    win      = '0;
    idx      = '0;
    for (int k = 0; k < NumIds; k++) begin
      idx = rr_q + IdWidth'(k);
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        win      = idx;
      end
    end
    deq     = any_elig && (!out_valid_q || out_ready_i);
    deq_ptr = head_q[win];
    for (int i = 0; i < NumIds; i++) begin
      enq_hit[i] = enq && (enq_id == IdWidth'(i));
      deq_hit[i] = deq && (win == IdWidth'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      id_count_o[i*CntW +: CntW] = len_q[i];
    end
    free_count_o = free_cnt_q;
    out_valid_o  = out_valid_q;
    data_o       = out_data_q;
  end

  // List bookkeeping, free bitmap, arbiter pointer and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        len_q[i]  <= '0;
      end
      free_q      <= '1;
      free_cnt_q  <= CntW'(Capacity);
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        if (enq_hit[i] && deq_hit[i]) begin
          // Length is unchanged; a single-entry list is replaced outright.
          head_q[i] <= (len_q[i] == CntW'(1)) ? alloc : next_q[head_q[i]];
          tail_q[i] <= alloc;
        end else if (enq_hit[i]) begin
          if (len_q[i] == '0) head_q[i] <= alloc;
          tail_q[i] <= alloc;
          len_q[i]  <= len_q[i] + CntW'(1);
        end else if (deq_hit[i]) begin
          head_q[i] <= next_q[head_q[i]];
          len_q[i]  <= len_q[i] - CntW'(1);
        end
      end
      if (enq) free_q[alloc] <= 1'b0;
      if (deq) free_q[deq_ptr] <= 1'b1;
      free_cnt_q <= free_cnt_q - CntW'(enq) + CntW'(deq);
      if (deq) begin
        rr_q        <= win + IdWidth'(1);
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[deq_ptr];
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Pool storage; link only when the list already has a tail.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[alloc] <= data_i;
      if (len_q[enq_id] != '0) next_q[tail_q[enq_id]] <= alloc;
    end
  end

endmodule

// File: tb/tb_simmem_linkedlist_bank_rr.sv
// Scoreboard bench for simmem_linkedlist_bank_rr: directed stimulus, expected
// outputs queued in release order and popped by an independent monitor.
module tb_simmem_linkedlist_bank_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  release_en;
  logic [63:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] id_count;
  logic [4:0]  free_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  simmem_linkedlist_bank_rr #(.DataWidth(64), .IdWidth(2), .Capacity(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .data_i      (data_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .release_en_i(release_en),
    .data_o      (data_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .id_count_o  (id_count),
    .free_count_o(free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [63:0] mk(input int tag, input int id);
    return (64'(tag) << 8) | 64'(id);
  endfunction

  function automatic logic [63:0] cnt(input int id);
    logic [19:0] v;
    v = id_count;
    return 64'(v[id*5 +: 5]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [63:0] d);
    data_in  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_unexpected: got %0h required none", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", data_out, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    in_valid   = 1'b0;
    release_en = 4'b0000;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_free", 64'(free_count), 64'd16);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Round trip: accept cycle 0, valid cycle 2.
    release_en = 4'b1111;
    out_ready  = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_AB02);
    enq(64'h0000_0000_0000_AB02);
    chk("rt_valid_c1", 64'(out_valid), 64'd0);
    chk("rt_free_c1", 64'(free_count), 64'd15);
    chk("rt_cnt2_c1", cnt(2), 64'd1);
    tick();
    chk("rt_valid_c2", 64'(out_valid), 64'd1);
    chk("rt_data_c2", data_out, 64'h0000_0000_0000_AB02);
    chk("rt_free_c2", 64'(free_count), 64'd16);
    tick();
    chk("rt_valid_c3", 64'(out_valid), 64'd0);
    wait_drain("rt_drain", 10);

    // Per-ID order with ID0 blocked.
    release_en = 4'b0010;
    exp_q.push_back(mk(10, 1));
    exp_q.push_back(mk(11, 1));
    exp_q.push_back(mk(12, 1));
    enq(mk(10, 1));
    enq(mk(11, 1));
    enq(mk(12, 1));
    enq(mk(13, 0));
    wait_drain("ord_drain", 20);
    tick();
    tick();
    chk("ord_cnt0", cnt(0), 64'd1);
    chk("ord_cnt1", cnt(1), 64'd0);
    chk("ord_valid", 64'(out_valid), 64'd0);
    chk("ord_free", 64'(free_count), 64'd15);
    exp_q.push_back(mk(13, 0));
    release_en = 4'b0011;
    wait_drain("ord_d_drain", 10);
    tick();
    chk("ord_cnt0_after", cnt(0), 64'd0);
    chk("ord_free_after", 64'(free_count), 64'd16);

    // Same-cycle enqueue/dequeue on a one-entry ID3 list.
    release_en = 4'b0000;
    exp_q.push_back(mk(20, 3));
    exp_q.push_back(mk(21, 3));
    enq(mk(20, 3));
    chk("sim_cnt3_pre", cnt(3), 64'd1);
    release_en = 4'b1000;
    enq(mk(21, 3));
    chk("sim_cnt3_mid", cnt(3), 64'd1);
    chk("sim_out_x", data_out, mk(20, 3));
    tick();
    chk("sim_out_y", data_out, mk(21, 3));
    chk("sim_cnt3_post", cnt(3), 64'd0);
    wait_drain("sim_drain", 10);
    tick();

    // Full pool; arbiter pointer is at 0 after the ID3 win.
    release_en = 4'b0000;
    out_ready  = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int id = 0; id < 4; id++) enq(mk(32 + k, id));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_free", 64'(free_count), 64'd0);
    enq(mk(99, 0));
    chk("full_17th_free", 64'(free_count), 64'd0);
    chk("full_17th_cnt0", cnt(0), 64'd4);
    release_en = 4'b1111;
    tick();
    release_en = 4'b0000;
    chk("full_rel_in_ready", 64'(in_ready), 64'd1);
    chk("full_rel_free", 64'(free_count), 64'd1);
    chk("full_rel_valid", 64'(out_valid), 64'd1);

    // Backpressure hold, then round-robin drain 0,1,2,3,...
    release_en = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_data_hold", data_out, mk(32, 0));
      chk("bp_free_hold", 64'(free_count), 64'd1);
    end
    for (int k = 0; k < 4; k++)
      for (int id = 0; id < 4; id++) exp_q.push_back(mk(32 + k, id));
    out_ready = 1'b1;
    wait_drain("rr_drain", 40);
    tick();
    chk("rr_free_after", 64'(free_count), 64'd16);
    for (int id = 0; id < 4; id++) chk("rr_cnt_after", cnt(id), 64'd0);

    // Asynchronous reset with data in flight.
    out_ready  = 1'b0;
    release_en = 4'b1111;
    enq(mk(40, 1));
    enq(mk(41, 1));
    enq(mk(42, 2));
    tick();
    chk("ar_valid_pre", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_data", data_out, 64'd0);
    chk("ar_free", 64'(free_count), 64'd16);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    for (int id = 0; id < 4; id++) chk("ar_cnt", cnt(id), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Function restored after reset.
    out_ready = 1'b1;
    exp_q.push_back(mk(50, 2));
    enq(mk(50, 2));
    wait_drain("post_rst_drain", 10);
    tick();
    chk("post_rst_free", 64'(free_count), 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
